// File: rtl/bram_arbiter_pkg.sv
// Shared types for the two-port BRAM arbiter: requester identity and read-tag format.
package bram_arbiter_pkg;

    // Owner bit of a read tag: 0 = requester a, 1 = requester b.
    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } read_tag_t;

    localparam read_tag_t TAG_IDLE = '{valid: 1'b0, owner: OWNER_A};

endpackage

// File: rtl/bram_arbiter_rr.sv
// Two-input round-robin grant: a lone requester wins outright, a tie goes to
// whichever side was not granted most recently.
module rr_arbiter2
    import bram_arbiter_pkg::*;
(
    input  logic   req_a,
    input  logic   req_b,
    input  owner_e last_grant,
    output logic   gnt_a,
    output logic   gnt_b
);

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (req_a && (!req_b || last_grant == OWNER_B)) begin
            gnt_a = 1'b1;
        end else if (req_b) begin
            gnt_b = 1'b1;
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// Arbitrates two requesters onto one single-port BRAM with zero-wait acks,
// round-robin on ties, and in-order read-data return two cycles after ack.
module bram_arbiter
    import bram_arbiter_pkg::*;
#(
    parameter int ADDRESS_BITWIDTH = 13,
    parameter int DATA_BITWIDTH    = 32
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,

    input  logic                        a_req,
    input  logic                        a_we,
    input  logic [ADDRESS_BITWIDTH-1:0] a_addr,
    input  logic [DATA_BITWIDTH-1:0]    a_wdata,
    output logic                        a_ack,
    output logic                        a_rvalid,
    output logic [DATA_BITWIDTH-1:0]    a_rdata,

    input  logic                        b_req,
    input  logic                        b_we,
    input  logic [ADDRESS_BITWIDTH-1:0] b_addr,
    input  logic [DATA_BITWIDTH-1:0]    b_wdata,
    output logic                        b_ack,
    output logic                        b_rvalid,
    output logic [DATA_BITWIDTH-1:0]    b_rdata,

    output logic                        mem_we,
    output logic [ADDRESS_BITWIDTH-1:0] mem_addr,
    output logic [DATA_BITWIDTH-1:0]    mem_din,
    input  logic [DATA_BITWIDTH-1:0]    mem_dout
);

    logic                        gnt_a;
    logic                        gnt_b;
    logic                        any_ack;
    logic                        sel_we;
    logic [ADDRESS_BITWIDTH-1:0] sel_addr;
    logic [DATA_BITWIDTH-1:0]    sel_wdata;

    logic                        mem_we_q,     mem_we_d;
    logic [ADDRESS_BITWIDTH-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_BITWIDTH-1:0]    mem_din_q,    mem_din_d;
    read_tag_t                   tag_q,        tag_d;
    logic                        a_rvalid_q,   a_rvalid_d;
    logic                        b_rvalid_q,   b_rvalid_d;
    owner_e                      last_grant_q, last_grant_d;

    rr_arbiter2 u_rr (
        .req_a      (a_req),
        .req_b      (b_req),
        .last_grant (last_grant_q),
        .gnt_a      (gnt_a),
        .gnt_b      (gnt_b)
    );

    // Acks are suppressed while reset is held so no operation is accepted then.
    assign a_ack   = gnt_a & sys_rst_n;
    assign b_ack   = gnt_b & sys_rst_n;
    assign any_ack = a_ack | b_ack;

    always_comb begin
        sel_we    = a_we;
        sel_addr  = a_addr;
        sel_wdata = a_wdata;
        if (b_ack) begin
            sel_we    = b_we;
            sel_addr  = b_addr;
            sel_wdata = b_wdata;
        end
    end

    always_comb begin
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        last_grant_d = last_grant_q;
        tag_d        = TAG_IDLE;
        if (any_ack) begin
            mem_we_d     = sel_we;
            mem_addr_d   = sel_addr;
            mem_din_d    = sel_wdata;
            last_grant_d = a_ack ? OWNER_A : OWNER_B;
            tag_d.valid  = !sel_we;
            tag_d.owner  = a_ack ? OWNER_A : OWNER_B;
        end
        // Second tag stage is the rvalid flops themselves, aligned with mem_dout.
        a_rvalid_d = tag_q.valid && (tag_q.owner == OWNER_A);
        b_rvalid_d = tag_q.valid && (tag_q.owner == OWNER_B);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            tag_q        <= TAG_IDLE;
            a_rvalid_q   <= 1'b0;
            b_rvalid_q   <= 1'b0;
            last_grant_q <= OWNER_B;
        end else begin
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            tag_q        <= tag_d;
            a_rvalid_q   <= a_rvalid_d;
            b_rvalid_q   <= b_rvalid_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = mem_dout;
    assign b_rdata  = mem_dout;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a behavioural one-cycle-latency BRAM.
module tb_bram_arbiter;

    localparam int AW = 13;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_ack, a_rvalid, b_ack, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    logic [DW-1:0] bram [0:(1<<AW)-1];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (mem_we) bram[mem_addr] <= mem_din;
        mem_dout <= bram[mem_addr];
    end

    bram_arbiter #(
        .ADDRESS_BITWIDTH (AW),
        .DATA_BITWIDTH    (DW)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_ack     (a_ack),
        .a_rvalid  (a_rvalid),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_ack     (b_ack),
        .b_rvalid  (b_rvalid),
        .b_rdata   (b_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    // Inputs change just after a falling edge; outputs are observed 1ns later.
    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        a_req = 1'b1; b_req = 1'b1;
        next_cycle();
        next_cycle();
        tests++; if (a_ack !== 1'b0 || b_ack !== 1'b0) begin fails++; $display("FAIL reset_acks: a_ack=%b b_ack=%b, required 0 0", a_ack, b_ack); end
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we: got %b, required 0", mem_we); end
        tests++; if (mem_addr !== '0 || mem_din !== '0) begin fails++; $display("FAIL reset_mem_bus: addr=%h din=%h, required 0 0", mem_addr, mem_din); end
        tests++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin fails++; $display("FAIL reset_rvalid: a=%b b=%b, required 0 0", a_rvalid, b_rvalid); end
        idle_inputs();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_write();
        a_req = 1'b1; a_we = 1'b1; a_addr = 13'd4; a_wdata = 32'hABCD_EF12;
        #1;
        tests++; if (a_ack !== 1'b1 || b_ack !== 1'b0) begin fails++; $display("FAIL write_ack: a_ack=%b b_ack=%b, required 1 0", a_ack, b_ack); end
        next_cycle();
        idle_inputs();
        tests++; if (mem_we !== 1'b1 || mem_addr !== 13'd4 || mem_din !== 32'hABCD_EF12) begin fails++; $display("FAIL write_mem: we=%b addr=%0d din=%h, required 1 4 abcdef12", mem_we, mem_addr, mem_din); end
        next_cycle();
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL write_we_drop: got %b, required 0", mem_we); end
    endtask

    task automatic test_read();
        a_req = 1'b1; a_we = 1'b0; a_addr = 13'd4;
        #1;
        tests++; if (a_ack !== 1'b1) begin fails++; $display("FAIL read_ack: got %b, required 1", a_ack); end
        next_cycle();
        idle_inputs();
        tests++; if (a_rvalid !== 1'b0 || mem_we !== 1'b0) begin fails++; $display("FAIL read_n1: rvalid=%b mem_we=%b, required 0 0", a_rvalid, mem_we); end
        next_cycle();
        tests++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hABCD_EF12) begin fails++; $display("FAIL read_n2: rvalid=%b rdata=%h, required 1 abcdef12", a_rvalid, a_rdata); end
        tests++; if (b_rvalid !== 1'b0) begin fails++; $display("FAIL read_b_quiet: b_rvalid=%b, required 0", b_rvalid); end
        next_cycle();
        tests++; if (a_rvalid !== 1'b0) begin fails++; $display("FAIL read_n3: rvalid=%b, required 0", a_rvalid); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ack;
        logic       exp_av, exp_bv;
        // Preload addr 1 via a and addr 2 via b; b is then the last grantee.
        a_req = 1'b1; a_we = 1'b1; a_addr = 13'd1; a_wdata = 32'h1111_1111;
        next_cycle();
        idle_inputs();
        b_req = 1'b1; b_we = 1'b1; b_addr = 13'd2; b_wdata = 32'h2222_2222;
        next_cycle();
        idle_inputs();
        next_cycle();
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                a_req = 1'b1; a_we = 1'b0; a_addr = 13'd1;
                b_req = 1'b1; b_we = 1'b0; b_addr = 13'd2;
            end else begin
                idle_inputs();
            end
            #1;
            exp_ack = (k >= 4) ? 2'b00 : ((k % 2 == 0) ? 2'b10 : 2'b01);
            exp_av  = (k >= 2) && ((k - 2) % 2 == 0);
            exp_bv  = (k >= 2) && ((k - 2) % 2 == 1);
            tests++; if ({a_ack, b_ack} !== exp_ack) begin fails++; $display("FAIL rr_ack[%0d]: a,b=%b%b, required %b", k, a_ack, b_ack, exp_ack); end
            tests++; if (a_rvalid !== exp_av || b_rvalid !== exp_bv) begin fails++; $display("FAIL rr_rvalid[%0d]: a,b=%b%b, required %b%b", k, a_rvalid, b_rvalid, exp_av, exp_bv); end
            if (exp_av) begin
                tests++; if (a_rdata !== 32'h1111_1111) begin fails++; $display("FAIL rr_adata[%0d]: got %h, required 11111111", k, a_rdata); end
            end
            if (exp_bv) begin
                tests++; if (b_rdata !== 32'h2222_2222) begin fails++; $display("FAIL rr_bdata[%0d]: got %h, required 22222222", k, b_rdata); end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        b_req = 1'b1; b_we = 1'b1; b_addr = 13'd7; b_wdata = 32'h5;
        #1;
        tests++; if (b_ack !== 1'b1 || a_ack !== 1'b0) begin fails++; $display("FAIL raw_wr_ack: a,b=%b%b, required 01", a_ack, b_ack); end
        next_cycle();
        idle_inputs();
        a_req = 1'b1; a_we = 1'b0; a_addr = 13'd7;
        #1;
        tests++; if (a_ack !== 1'b1) begin fails++; $display("FAIL raw_rd_ack: got %b, required 1", a_ack); end
        next_cycle();
        idle_inputs();
        next_cycle();
        tests++; if (a_rvalid !== 1'b1 || a_rdata !== 32'h5) begin fails++; $display("FAIL raw_data: rvalid=%b rdata=%h, required 1 00000005", a_rvalid, a_rdata); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        a_req = 1'b1; a_we = 1'b0; a_addr = 13'd4;
        #1;
        tests++; if (a_ack !== 1'b1) begin fails++; $display("FAIL rstmid_ack: got %b, required 1", a_ack); end
        next_cycle();
        idle_inputs();
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            if (k == 1) rst_n = 1'b1;
            tests++; if (a_rvalid !== 1'b0 || mem_we !== 1'b0) begin fails++; $display("FAIL rstmid_quiet[%0d]: rvalid=%b mem_we=%b, required 0 0", k, a_rvalid, mem_we); end
        end
        a_req = 1'b1; a_we = 1'b0; a_addr = 13'd1;
        b_req = 1'b1; b_we = 1'b0; b_addr = 13'd2;
        #1;
        tests++; if (a_ack !== 1'b1 || b_ack !== 1'b0) begin fails++; $display("FAIL rstmid_tie: a,b=%b%b, required 10", a_ack, b_ack); end
        next_cycle();
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_idle();
        int bad = 0;
        idle_inputs();
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            tests++; if (a_ack !== 1'b0 || b_ack !== 1'b0 || mem_we !== 1'b0) begin fails++; bad++; $display("FAIL idle[%0d]: a_ack=%b b_ack=%b mem_we=%b, required 0 0 0", k, a_ack, b_ack, mem_we); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        #1;
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_back_to_back();
        test_reset_mid();
        test_idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_BITWIDTH, default 13, meaning the memory word-address width.
REQ-002 SHALL have parameter DATA_BITWIDTH, default 32, meaning the memory word width.
REQ-003 SHALL have one clock and a synchronous, active-low reset: sys_clk and sys_rst_n.
REQ-004 sys_clk  in  1  clock; all state changes on its rising edge.
REQ-005 sys_rst_n  in  1  synchronous active-low reset.
REQ-006 For p in {a,b}, the following four ports: p_req  in  1  requester p has an operation pending.
REQ-007 p_we  in  1  1 = write, 0 = read; qualified by p_req.
REQ-008 p_addr  in  ADDRESS_BITWIDTH  word address; qualified by p_req.
REQ-009 p_wdata  in  DATA_BITWIDTH  write data; qualified by p_req & p_we.
REQ-010 p_ack  out  1  combinational; high in the cycle the operation of p is accepted.
REQ-011 p_rvalid  out  1  registered; high for one cycle when read data for p is valid.
REQ-012 p_rdata  out  DATA_BITWIDTH  read data; meaningful only while p_rvalid.
REQ-013 mem_we  out  1  registered write enable to the single-port BRAM.
REQ-014 mem_addr  out  ADDRESS_BITWIDTH  registered BRAM address.
REQ-015 mem_din  out  DATA_BITWIDTH  registered BRAM write data.
REQ-016 mem_dout  in  DATA_BITWIDTH  BRAM read data; valid one cycle after the address is sampled.

Function
REQ-017 Handshake: requester holds p_req/p_we/p_addr/p_wdata stable until it samples p_ack high; it may present a new operation in the next cycle.
REQ-018 At most one of a_ack, b_ack SHALL be high per cycle; p_ack is never high unless p_req is high.
REQ-019 Only one requester requesting: it SHALL be acked in the same cycle (zero wait).
REQ-020 Both requesting: the requester not granted most recently SHALL win (round-robin); a last_grant register updates on every ack.
REQ-021 Throughput: one accepted operation per cycle; back-to-back acks to the same requester are allowed when the other is idle.
REQ-022 Ack in cycle N: at the edge ending N, mem_addr <= p_addr, mem_din <= p_wdata, mem_we <= p_we.
REQ-023 No ack in cycle N: at the edge ending N, mem_we <= 0; mem_addr and mem_din hold.
REQ-024 Read acked in cycle N: p_rvalid SHALL be high in cycle N+2 only, with p_rdata = mem_dout.
REQ-025 Writes SHALL produce no rvalid.
REQ-026 Read-tag pipeline is two stages deep, holding {valid, owner}; reads from both requesters may be in flight simultaneously, and data returns in ack order.
REQ-027 Memory ordering equals ack order: a read acked after a write to the same address returns the new data.

Reset
REQ-028 While sys_rst_n is low at an edge: mem_we=0, mem_addr=0, mem_din=0, both rvalid=0, tag pipeline cleared, last_grant=b (so a wins the first tie).
REQ-029 During reset cycles a_ack and b_ack SHALL be 0.
REQ-030 Reset mid-operation: in-flight reads are discarded and yield no rvalid after reset; no BRAM write occurs in the first cycle after reset release.

Structure
REQ-031 No shared package is required; widths are parameters only, and the tag encoding (owner bit: 0=a, 1=b) is a localparam.
REQ-032 One sub-module is natural: rr_arbiter2 (combinational grant from two requests plus last_grant).
REQ-033 The BRAM is instantiated outside bram_arbiter, which connects to it via mem_* only.

Verification
REQ-034 Reset, then a writes 0xABCD_EF12 to addr 4 -> a_ack in the same cycle, and mem_we=1, mem_addr=4 the next cycle.
REQ-035 After REQ-034, a reads addr 4 (ack in cycle N) -> a_rvalid only in N+2, a_rdata=0xABCD_EF12; b_rvalid stays 0.
REQ-036 a and b both hold reads for 4 cycles, to addr 1 and 2 respectively -> acks go a,b,a,b; rvalids alternate two cycles behind with correct data.
REQ-037 b writes 0x5 to addr 7 and a reads addr 7 in the next cycle -> a_rdata=0x5.
REQ-038 Reset asserted one cycle after a read ack -> no a_rvalid; mem_we=0 after reset; the first tie after reset goes to a.
REQ-039 Idle for 10 cycles -> mem_we=0 and no acks throughout.
